// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: sequences ALU, IR, PC and
// register file, and guards every memory wait with a bounded stall counter.
module multicycle_controller #(
  parameter int STALL_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemReq,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUOp,
  output logic       IllegalInstr,
  output logic       MemTimeout,
  output logic [3:0] State
);

  localparam int CW = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [CW-1:0]   stall_cnt;
  logic            waiting;
  logic            timeout;
  logic            pc_update;
  logic            branch;
  logic            bad_op;

  assign waiting = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  assign timeout = (STALL_LIMIT > 0) && waiting && !MemReady &&
                   (stall_cnt == CW'(STALL_LIMIT));

  always_comb begin
    next_state = S_FETCH;
    bad_op     = 1'b0;
    case (state)
      S_FETCH:    next_state = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_R:              next_state = S_EXECR;
          OP_I:              next_state = S_EXECI;
          OP_BEQ:            next_state = S_BEQ;
          OP_JAL:            next_state = S_JAL;
          default: begin
            next_state = S_FETCH;
            bad_op     = 1'b1;
          end
        endcase
      end
      S_MEMADR:   next_state = (Op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  next_state = MemReady ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: next_state = MemReady ? S_FETCH : S_MEMWRITE;
      S_EXECR:    next_state = S_ALUWB;
      S_EXECI:    next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_BEQ:      next_state = S_FETCH;
      S_JAL:      next_state = S_ALUWB;
      default:    next_state = S_FETCH;
    endcase
    if (timeout) next_state = S_FETCH;
  end

  // A timeout out of FETCH keeps the same state, so the clear is explicit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      stall_cnt <= '0;
    end else begin
      state <= next_state;
      if (timeout || (next_state != state))
        stall_cnt <= '0;
      else if (waiting && !MemReady)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_comb begin
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 2'b00;
    pc_update = 1'b0;
    branch    = 1'b0;
    case (state)
      S_FETCH: begin
        MemReq    = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        pc_update = MemReady;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB:  RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        branch  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCWrite      = pc_update | (branch & Zero);
  assign IllegalInstr = bad_op;
  assign MemTimeout   = timeout;
  assign State        = state;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Main control FSM for the multicycle RV32I core. It sequences the shared ALU, instruction register, PC and register file over several cycles per instruction. It drives the 2-bit ALUOp consumed by the existing ALU decoder, which maps ALUOp/Funct3/Funct7 to ALUControl. It also owns the memory request/ready handshake with a bounded stall timeout.

Parameters:
STALL_LIMIT, 15, maximum consecutive cycles waiting on MemReady before abort; 0 disables the timeout (wait forever).

Ports:
clk  input  1  core clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; forces state to FETCH and clears the stall counter
Op  input  7  opcode field of the instruction register
Zero  input  1  ALU zero flag
MemReady  input  1  memory completes the current access this cycle
MemReq  output  1  memory access request (FETCH, MEMREAD, MEMWRITE)
MemWrite  output  1  store strobe
AdrSrc  output  1  0 = PC, 1 = ALUOut as memory address
IRWrite  output  1  load instruction register
PCWrite  output  1  PC load enable
RegWrite  output  1  register file write enable
ALUSrcA  output  2  00 PC, 01 OldPC, 10 rs1 data
ALUSrcB  output  2  00 rs2 data, 01 ImmExt, 10 constant 4
ResultSrc  output  2  00 ALUOut, 01 read data, 10 ALUResult
ALUOp  output  2  00 add, 01 subtract/compare, 10 decode funct fields
IllegalInstr  output  1  one-cycle pulse when DECODE sees an unsupported opcode
MemTimeout  output  1  one-cycle pulse when STALL_LIMIT is exceeded
State  output  4  current state encoding (debug)

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10. Encodings 11–15 go to FETCH on the next edge, with all outputs at 0.
- Outputs are Moore, decoded from State, with these exceptions: IRWrite and the PC update in FETCH are qualified by MemReady; PCWrite = PCUpdate | (Branch & Zero), where PCUpdate and Branch are internal signals.
- Any signal not listed for a state below is 0 in that state.
- Reset: state = FETCH, stall counter = 0. Outputs during and after reset are FETCH outputs:
  - MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALUOp=00.
  - IRWrite = PCWrite = MemReady; all other outputs 0.
- FETCH: as above. MemReady=1 → DECODE; otherwise stay.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by Op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other opcode → FETCH with IllegalInstr=1 for this cycle.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: Op=0000011 → MEMREAD, else → MEMWRITE.
- MEMREAD: MemReq=1, AdrSrc=1, ResultSrc=00. MemReady → MEMWB; otherwise stay.
- MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
- MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1, ResultSrc=00. MemWrite is held until MemReady; MemReady → FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 → ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 → FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 → ALUWB.
- Instruction latency in cycles, with zero wait states: lw 5, sw 4, R/I 4, beq 3, jal 4.
- Stall counter, width clog2(STALL_LIMIT+1):
  - Increments each cycle the FSM is in FETCH, MEMREAD or MEMWRITE with MemReady=0.
  - Clears on any state change.
  - If STALL_LIMIT>0 and the counter equals STALL_LIMIT while MemReady=0: MemTimeout=1 for that cycle, next state = FETCH, counter cleared.
  - If MemReady=1 in the same cycle, MemReady wins: normal transition, no timeout.
- Reset asserted mid-instruction (including during a stall) aborts immediately to FETCH; no RegWrite or MemWrite occurs after reset is asserted.

Test Plan:
- Reset, MemReady=1, Op=0110011 → State sequence 0,1,6,8,0. ALUOp=10 in EXECR; RegWrite=1 only in ALUWB.
- Op=0000011, MemReady low for 3 cycles in MEMREAD → State holds at 3 for 3 cycles, then 4. MemReq=1 and AdrSrc=1 throughout; lw takes 8 cycles in total.
- Op=1100011, Zero=1 → PCWrite=1 in BEQ with ALUOp=01. Repeat with Zero=0 → PCWrite=0.
- Op=1101111 → State sequence 1,10,8,0. PCWrite=1 in JAL; RegWrite=1 in ALUWB.
- Op=1111111 in DECODE → IllegalInstr=1 for exactly 1 cycle, then State=0 with no RegWrite. STALL_LIMIT=15 with MemReady=0 in FETCH → MemTimeout pulses on the 16th cycle in FETCH and the stall counter returns to 0.
- Assert reset while in MEMWRITE with MemReady=0 → State=0 asynchronously and MemWrite drops within the same cycle.
